// File: rtl/gf180mcu_fd_sc_mcu7t5v0__share_arb_pkg.sv
// Shared types and helpers for the round-robin arbiter that time-shares one NAND2 cell.
package gf180mcu_fd_sc_mcu7t5v0__share_arb_pkg;

  typedef enum logic [1:0] {IDLE, EVAL, RESP} arb_state_t;

  localparam int N_REQ_MAX = 16;

  // Last-winner pointer after reset; the top requester index gives requester 0 first priority.
  function automatic int rst_ptr(input int n_req);
    return n_req - 1;
  endfunction

  // Rotating-priority search starting at ptr+1 with wrap; returns {found, index}.
  function automatic logic [4:0] rr_pick_f(input logic [N_REQ_MAX-1:0] req,
                                           input logic [3:0] ptr,
                                           input int n_req);
    logic [4:0] res;
    int         j;
    res = '0;
    for (int i = 1; i <= N_REQ_MAX; i++) begin
      if (i <= n_req) begin
        j = (int'(ptr) + i) % n_req;
        if (!res[4] && req[j[3:0]]) res = {1'b1, j[3:0]};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__rr_pick.sv
// Combinational round-robin picker: masked request vector in, one-hot winner, index and found flag out.
module gf180mcu_fd_sc_mcu7t5v0__rr_pick
  import gf180mcu_fd_sc_mcu7t5v0__share_arb_pkg::*;
#(
  parameter int  N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  input  logic [N_REQ-1:0] excl,
  output logic [N_REQ-1:0] win_oh,
  output logic [IDX_W-1:0] win_idx,
  output logic             found
);

  logic [N_REQ_MAX-1:0] req_ext;
  logic [4:0]           pick;

  always_comb begin
    req_ext            = '0;
    req_ext[N_REQ-1:0] = req & ~excl;
    pick               = rr_pick_f(req_ext, 4'(ptr), N_REQ);
    found              = pick[4];
    win_idx            = IDX_W'(pick[3:0]);
    win_oh             = '0;
    if (pick[4]) win_oh[win_idx] = 1'b1;
  end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__nand2_share_arb.sv
// Round-robin scheduler sharing one external NAND2 among N_REQ requesters.
// Define GF180MCU_FD_SC_MCU7T5V0_SHARE_ARB_LOCK_EN to add the LOCK burst input.
module gf180mcu_fd_sc_mcu7t5v0__nand2_share_arb
  import gf180mcu_fd_sc_mcu7t5v0__share_arb_pkg::*;
#(
  parameter int  N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_REQ-1:0] REQ,
  input  logic [N_REQ-1:0] REQ_A1,
  input  logic [N_REQ-1:0] REQ_A2,
`ifdef GF180MCU_FD_SC_MCU7T5V0_SHARE_ARB_LOCK_EN
  input  logic [N_REQ-1:0] LOCK,
`endif
  output logic [N_REQ-1:0] GNT,
  output logic             SH_A1,
  output logic             SH_A2,
  input  logic             SH_ZN,
  output logic [N_REQ-1:0] ACK,
  output logic             ZN,
  output logic [IDX_W-1:0] ACK_ID
);

  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d, ack_q, ack_d;
  logic             sh_a1_q, sh_a1_d, sh_a2_q, sh_a2_d, zn_q, zn_d;
  logic [IDX_W-1:0] ack_id_q, ack_id_d, ptr_q, ptr_d;
  logic             lock_q, lock_d;

  logic [N_REQ-1:0] excl, pick_oh, grant_oh;
  logic [IDX_W-1:0] pick_idx, grant_idx;
  logic             pick_found, grant_en;

  // The just-acknowledged requester sits out the RESP-cycle decision.
  assign excl = (state_q == RESP) ? ack_q : '0;

  gf180mcu_fd_sc_mcu7t5v0__rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req     (REQ),
    .ptr     (ptr_q),
    .excl    (excl),
    .win_oh  (pick_oh),
    .win_idx (pick_idx),
    .found   (pick_found)
  );

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sh_a1_d   = sh_a1_q;
    sh_a2_d   = sh_a2_q;
    ack_d     = ack_q;
    zn_d      = zn_q;
    ack_id_d  = ack_id_q;
    ptr_d     = ptr_q;
    lock_d    = lock_q;
    grant_en  = 1'b0;
    grant_oh  = pick_oh;
    grant_idx = pick_idx;
    unique case (state_q)
      IDLE: grant_en = pick_found;
      EVAL: begin
        zn_d     = SH_ZN;
        ack_d    = gnt_q;
        ack_id_d = ptr_q;
        gnt_d    = '0;
        state_d  = RESP;
`ifdef GF180MCU_FD_SC_MCU7T5V0_SHARE_ARB_LOCK_EN
        lock_d   = LOCK[ptr_q];
`else
        lock_d   = 1'b0;
`endif
      end
      RESP: begin
        ack_d    = '0;
        grant_en = pick_found;
        // A held lock re-grants the same requester without moving the pointer.
        if (lock_q && REQ[ptr_q]) begin
          grant_en  = 1'b1;
          grant_oh  = ack_q;
          grant_idx = ptr_q;
        end
        if (!grant_en) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (grant_en) begin
      gnt_d   = grant_oh;
      sh_a1_d = REQ_A1[grant_idx];
      sh_a2_d = REQ_A2[grant_idx];
      ptr_d   = grant_idx;
      state_d = EVAL;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      ack_q    <= '0;
      sh_a1_q  <= 1'b0;
      sh_a2_q  <= 1'b0;
      zn_q     <= 1'b1;
      ack_id_q <= '0;
      ptr_q    <= IDX_W'(rst_ptr(N_REQ));
      lock_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      ack_q    <= ack_d;
      sh_a1_q  <= sh_a1_d;
      sh_a2_q  <= sh_a2_d;
      zn_q     <= zn_d;
      ack_id_q <= ack_id_d;
      ptr_q    <= ptr_d;
      lock_q   <= lock_d;
    end
  end

  assign GNT    = gnt_q;
  assign ACK    = ack_q;
  assign SH_A1  = sh_a1_q;
  assign SH_A2  = sh_a2_q;
  assign ZN     = zn_q;
  assign ACK_ID = ack_id_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__nand2_share_arb.sv
// Directed bench for the shared-NAND2 round-robin arbiter, with a behavioural NAND2 on the shared port.
module tb_gf180mcu_fd_sc_mcu7t5v0__nand2_share_arb;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0, a1 = '0, a2 = '0;
  logic [3:0] gnt, ack;
  logic       sh_a1, sh_a2, sh_zn, zn;
  logic [1:0] ack_id;
`ifdef GF180MCU_FD_SC_MCU7T5V0_SHARE_ARB_LOCK_EN
  logic [3:0] lock = '0;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign sh_zn = ~(sh_a1 & sh_a2);

  gf180mcu_fd_sc_mcu7t5v0__nand2_share_arb #(.N_REQ(4)) dut (
    .CLK    (clk),
    .RST    (rst),
    .REQ    (req),
    .REQ_A1 (a1),
    .REQ_A2 (a2),
`ifdef GF180MCU_FD_SC_MCU7T5V0_SHARE_ARB_LOCK_EN
    .LOCK   (lock),
`endif
    .GNT    (gnt),
    .SH_A1  (sh_a1),
    .SH_A2  (sh_a2),
    .SH_ZN  (sh_zn),
    .ACK    (ack),
    .ZN     (zn),
    .ACK_ID (ack_id)
  );

  typedef struct {
    logic [3:0] req;
    logic [3:0] a1;
    logic [3:0] a2;
    logic [1:0] id;
    logic [1:0] sh;
    logic       zn;
  } vec_t;

  vec_t vecs[7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         nack;
    int         last;
    logic [3:0] rearm;
    logic [3:0] oh;
    logic [1:0] exp_lock [4];

    // Expected winners assume the pointer carried over from the previous vector.
    vecs[0] = '{4'b0100, 4'b0100, 4'b0100, 2'd2, 2'b11, 1'b0};
    vecs[1] = '{4'b0100, 4'b0100, 4'b0000, 2'd2, 2'b10, 1'b1};
    vecs[2] = '{4'b1001, 4'b1000, 4'b1000, 2'd3, 2'b11, 1'b0};
    vecs[3] = '{4'b1001, 4'b0001, 4'b0000, 2'd0, 2'b10, 1'b1};
    vecs[4] = '{4'b1111, 4'b0010, 4'b0010, 2'd1, 2'b11, 1'b0};
    vecs[5] = '{4'b0001, 4'b0000, 4'b0001, 2'd0, 2'b01, 1'b1};
    vecs[6] = '{4'b1000, 4'b1000, 4'b1000, 2'd3, 2'b11, 1'b0};

    // Reset then idle
    rst = 1'b1;
    step();
    step();
    check("reset_state", {gnt, ack, zn, sh_a1, sh_a2, ack_id}, {4'b0, 4'b0, 1'b1, 1'b0, 1'b0, 2'd0});
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      check("idle_hold", {gnt, ack, zn, sh_a1, sh_a2}, {4'b0, 4'b0, 1'b1, 1'b0, 1'b0});
    end

    // Table of single operations
    for (int i = 0; i < 7; i++) begin
      oh  = 4'b0001 << vecs[i].id;
      req = vecs[i].req;
      a1  = vecs[i].a1;
      a2  = vecs[i].a2;
      step();
      check($sformatf("v%0d_gnt", i), gnt, oh);
      check($sformatf("v%0d_sh", i), {sh_a1, sh_a2}, vecs[i].sh);
      check($sformatf("v%0d_noack", i), ack, 4'b0);
      step();
      check($sformatf("v%0d_ack", i), ack, oh);
      check($sformatf("v%0d_id", i), ack_id, vecs[i].id);
      check($sformatf("v%0d_zn", i), zn, vecs[i].zn);
      check($sformatf("v%0d_gnt0", i), gnt, 4'b0);
      req = '0;
      step();
      check($sformatf("v%0d_ack_drop", i), {gnt, ack}, 8'h00);
    end

    // Fairness: all four requesting, each drops for one cycle after its ack
    req   = 4'b1111;
    a1    = '0;
    a2    = '0;
    nack  = 0;
    last  = 0;
    rearm = '0;
    for (int c = 0; c < 40 && nack < 8; c++) begin
      step();
      req   = req | rearm;
      rearm = '0;
      check("gnt_ack_excl", (gnt != 0) && (ack != 0), 1'b0);
      if (ack != 0) begin
        check("fair_id", ack_id, nack % 4);
        check("fair_oh", ack, 32'(1) << (nack % 4));
        if (nack > 0) check("fair_gap", c - last, 2);
        last  = c;
        nack++;
        req   = req & ~ack;
        rearm = ack;
      end
    end
    check("fair_count", nack, 8);
    req = '0;
    step();
    step();
    check("fair_drain", {gnt, ack}, 8'h00);

    // Operands are captured at grant
    req = 4'b0010;
    a1  = 4'b0010;
    a2  = 4'b0010;
    step();
    check("cap_gnt", gnt, 4'b0010);
    a1 = '0;
    a2 = '0;
    step();
    check("cap_ack", ack, 4'b0010);
    check("cap_zn", zn, 1'b0);
    req = '0;
    step();

    // Request withdrawn before ack still completes
    req = 4'b0001;
    a1  = 4'b0001;
    a2  = 4'b0000;
    step();
    req = '0;
    step();
    check("drop_ack", ack, 4'b0001);
    check("drop_zn", zn, 1'b1);
    step();
    check("drop_ack_end", ack, 4'b0000);

    // Reset during EVAL aborts the operation and restores the pointer
    req = 4'b0100;
    a1  = 4'b0100;
    a2  = 4'b0100;
    step();
    check("rst_gnt", gnt, 4'b0100);
    rst = 1'b1;
    req = '0;
    step();
    check("rst_mid_state", {gnt, ack, zn, sh_a1, sh_a2}, {4'b0, 4'b0, 1'b1, 1'b0, 1'b0});
    rst = 1'b0;
    step();
    check("rst_no_ack", ack, 4'b0000);
    req = 4'b1010;
    step();
    check("rst_ptr_gnt", gnt, 4'b0010);
    step();
    check("rst_ptr_ack", {ack, 2'b00, ack_id}, {4'b0010, 2'b00, 2'd1});
    req = '0;
    step();

`ifdef GF180MCU_FD_SC_MCU7T5V0_SHARE_ARB_LOCK_EN
    // Move the pointer to 0, then burst requester 1 under LOCK
    req = 4'b0001;
    step();
    step();
    req = '0;
    step();
    exp_lock = '{2'd1, 2'd1, 2'd1, 2'd0};
    req  = 4'b0011;
    lock = 4'b0010;
    nack = 0;
    last = 0;
    for (int c = 0; c < 30 && nack < 4; c++) begin
      step();
      if (ack != 0) begin
        check("lock_id", ack_id, exp_lock[nack]);
        if (nack > 0) check("lock_gap", c - last, 2);
        last = c;
        nack++;
        if (nack == 2) lock = '0;
        if (nack == 3) req[1] = 1'b0;
        if (nack == 4) req = '0;
      end
    end
    check("lock_count", nack, 4);
    step();
    step();
`else
    exp_lock = '{2'd0, 2'd0, 2'd0, 2'd0};
    oh       = exp_lock[0];
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
